// File: rtl/uart_echo_fifo.sv
// UART receiver -> FIFO -> UART transmitter echo path with sticky error flags.
// Optional CR -> CR,LF expansion when UART_ECHO_CRLF_EN is defined.
module uart_echo_fifo #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic                          txd,
    input  logic                          tx_enable,
    input  logic                          clr_err,
    output logic                          rx_strobe,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          tx_busy,
    output logic                          overrun_err,
    output logic                          frame_err,
    output logic                          parity_err
);
    localparam int CPB   = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
    localparam logic [3:0]       LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 rx_state, tx_state;
    logic                   rx_meta, rx_sync;
    logic [CNT_W-1:0]       rx_cnt, tx_cnt;
    logic [3:0]             rx_bit, tx_bit;
    logic [DATA_BITS-1:0]   rx_sh, tx_sh;
    logic                   rx_par, tx_par, tx_stop;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   stop_samp, par_bad, good_frame, room;
    logic                   rx_accept, rx_drop, lf_pend, push, pop;
    logic [DATA_BITS-1:0]   push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rx_sync) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (rx_cnt == FULL) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_sync, rx_sh[DATA_BITS-1:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_PARITY: begin
                    if (rx_cnt == FULL) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= S_STOP;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (rx_cnt == FULL) rx_state <= S_IDLE;
                    else rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Everything about the received frame is decided in the stop-sample cycle.
    assign stop_samp  = (rx_state == S_STOP) && (rx_cnt == FULL);
    assign par_bad    = (PARITY != 0) && ((^rx_sh ^ rx_par) != (PARITY == 1));
    assign good_frame = stop_samp && rx_sync && !par_bad;
    assign rx_accept  = good_frame && room;
    assign rx_drop    = good_frame && !room;

`ifdef UART_ECHO_CRLF_EN
    logic is_cr;
    assign is_cr = (DATA_BITS == 8) && (rx_sh == DATA_BITS'(13));
    assign room  = is_cr ? (fifo_count <= CW'(FIFO_DEPTH - 2)) : !fifo_full;
    always_ff @(posedge clk) begin
        if (rst) lf_pend <= 1'b0;
        else     lf_pend <= rx_accept && is_cr;
    end
`else
    assign room    = !fifo_full;
    assign lf_pend = 1'b0;
`endif

    assign push      = rx_accept || lf_pend;
    assign push_data = lf_pend ? DATA_BITS'(10) : rx_sh;
    assign pop       = (tx_state == S_IDLE) && tx_enable && (fifo_count != '0);
    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign tx_busy   = (tx_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rx_strobe   <= 1'b0;
            rx_data     <= '0;
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            rx_strobe   <= rx_accept;
            if (rx_accept) rx_data <= rx_sh;
            overrun_err <= rx_drop | (overrun_err & ~clr_err);
            frame_err   <= (stop_samp & ~rx_sync) | (frame_err & ~clr_err);
            parity_err  <= (stop_samp & par_bad) | (parity_err & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            txd      <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_stop  <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        tx_sh    <= mem[rd_ptr];
                        tx_par   <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
                        txd      <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_stop  <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == FULL) begin
                        tx_cnt   <= '0;
                        txd      <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_state <= S_DATA;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (tx_cnt == FULL) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST) begin
                            txd      <= (PARITY != 0) ? tx_par : 1'b1;
                            tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            txd    <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_PARITY: begin
                    if (tx_cnt == FULL) begin
                        tx_cnt   <= '0;
                        txd      <= 1'b1;
                        tx_state <= S_STOP;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (tx_cnt == FULL) begin
                        tx_cnt <= '0;
                        if (tx_stop == 1'(STOP_BITS - 1)) tx_state <= S_IDLE;
                        else tx_stop <= tx_stop + 1'b1;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench: 8N1 instance (a) and even-parity instance (b), both CPB=10, depth 4.
module tb_uart_echo_fifo;
    localparam int CPB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rxd_a, rxd_b, en_a, en_b, clr_a, clr_b;
    logic       txd_a, strb_a, full_a, busy_a, ovr_a, fer_a, per_a;
    logic       txd_b, strb_b, full_b, busy_b, ovr_b, fer_b, per_b;
    logic [7:0] data_a, data_b;
    logic [2:0] cnt_a, cnt_b;

    uart_echo_fifo #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .txd(txd_a), .tx_enable(en_a), .clr_err(clr_a),
        .rx_strobe(strb_a), .rx_data(data_a), .fifo_count(cnt_a), .fifo_full(full_a),
        .tx_busy(busy_a), .overrun_err(ovr_a), .frame_err(fer_a), .parity_err(per_a));

    uart_echo_fifo #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .txd(txd_b), .tx_enable(en_b), .clr_err(clr_b),
        .rx_strobe(strb_b), .rx_data(data_b), .fifo_count(cnt_b), .fifo_full(full_b),
        .tx_busy(busy_b), .overrun_err(ovr_b), .frame_err(fer_b), .parity_err(per_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observers: strobe counters, pop timestamp and txd frame decoders
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          strb_n_a = 0, strb_n_b = 0;
    logic [7:0]  last_a = '0, last_b = '0;
    logic [2:0]  prev_cnt_a = '0;
    int          pop_cyc_a = -1, start_cyc_a = -2;
    logic [1:0]  txv;
    bit          mon_act [2];
    int          mon_n   [2];
    int          wbad    [2];
    logic [10:0] mon_bits[2];
    logic [10:0] frames_a[$];
    logic [10:0] frames_b[$];
    assign txv = {txd_b, txd_a};

    initial begin
        mon_act[0] = 0; mon_act[1] = 0;
        wbad[0] = 0;    wbad[1] = 0;
    end

    always @(negedge clk) begin : observe
        int nb, bi;
        if (strb_a) begin strb_n_a++; last_a = data_a; end
        if (strb_b) begin strb_n_b++; last_b = data_b; end
        if (!rst && cnt_a < prev_cnt_a) pop_cyc_a = cyc;
        prev_cnt_a = cnt_a;
        for (int k = 0; k < 2; k++) begin
            nb = (k == 0) ? 10 : 11;
            if (rst) mon_act[k] = 0;
            else begin
                if (!mon_act[k] && txv[k] == 1'b0) begin
                    mon_act[k]  = 1;
                    mon_n[k]    = 0;
                    mon_bits[k] = '1;
                    if (k == 0) start_cyc_a = cyc;
                end
                if (mon_act[k]) begin
                    bi = mon_n[k] / CPB;
                    if (mon_n[k] % CPB == 0) mon_bits[k][bi] = txv[k];
                    else if (mon_bits[k][bi] !== txv[k]) wbad[k]++;
                    mon_n[k]++;
                    if (mon_n[k] == nb * CPB) begin
                        mon_act[k] = 0;
                        if (k == 0) frames_a.push_back(mon_bits[0]);
                        else        frames_b.push_back(mon_bits[1]);
                    end
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v, input int n);
        @(negedge clk);
        if (sel == 0) rxd_a = v; else rxd_b = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input bit has_par,
                        input bit pb, input bit stopv);
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
        if (has_par) drive(sel, pb, CPB);
        drive(sel, stopv, CPB);
        drive(sel, 1'b1, 12);
    endtask

    task automatic wait_frames(input int sel, input int n, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (sel == 0 && frames_a.size() >= n) break;
            if (sel == 1 && frames_b.size() >= n) break;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stopv;
        bit         clr_before;
        int         d_strb;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        bit         e_full;
        bit         e_ovr;
        bit         e_fer;
    } vec_t;
    vec_t tbl[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        logic [10:0] fr;
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 8'h55, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h11, 1'b1, 1'b1, 1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b0, 1, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h33, 1'b1, 1'b0, 1, 8'h33, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h44, 1'b1, 1'b0, 1, 8'h44, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h55, 1'b1, 1'b0, 0, 8'h44, 3'd4, 1'b1, 1'b1, 1'b0};

        rst = 1; rxd_a = 1; rxd_b = 1; en_a = 1; en_b = 1; clr_a = 0; clr_b = 0;
        repeat (3) @(negedge clk);
        check("rst_txd",    txd_a,  1);
        check("rst_count",  cnt_a,  0);
        check("rst_full",   full_a, 0);
        check("rst_busy",   busy_a, 0);
        check("rst_strobe", strb_a, 0);
        check("rst_rxdata", data_a, 0);
        check("rst_errs",   {ovr_a, fer_a, per_a}, 0);
        rst = 0;

        // Short low pulse on rxd must be rejected as a glitch
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 20);
        check("glitch_strobe", strb_n_a, 0);
        check("glitch_errs",   {ovr_a, fer_a, per_a}, 0);
        check("glitch_no_tx",  frames_a.size(), 0);

        // 8N1 echo of 0x55 with exact bit timing
        send(0, 8'h55, 0, 0, 1);
        check("t1_busy_mid", busy_a, 1);
        wait_frames(0, 1, 300);
        check("t1_frames", frames_a.size(), 1);
        check("t1_strobes", strb_n_a, 1);
        check("t1_rxdata", last_a, 8'h55);
        if (frames_a.size() > 0) begin
            fr = frames_a.pop_front();
            check("t1_frame", fr, {2'b11, 8'h55, 1'b0});
        end
        check("t1_start_after_pop", start_cyc_a, pop_cyc_a);
        check("t1_bit_width", wbad[0], 0);
        repeat (2) @(negedge clk);
        check("t1_busy_end", busy_a, 0);
        check("t1_count_end", cnt_a, 0);

        // Frame error, then fill with TX held and overflow
        en_a = 0;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr_before) begin
                @(negedge clk) clr_a = 1;
                @(negedge clk) clr_a = 0;
            end
            s0 = strb_n_a;
            send(0, tbl[i].d, 0, 0, tbl[i].stopv);
            check($sformatf("tbl%0d_strobes", i), strb_n_a - s0, tbl[i].d_strb);
            check($sformatf("tbl%0d_rxdata", i),  last_a, tbl[i].e_data);
            check($sformatf("tbl%0d_count", i),   cnt_a,  tbl[i].e_cnt);
            check($sformatf("tbl%0d_full", i),    full_a, tbl[i].e_full);
            check($sformatf("tbl%0d_overrun", i), ovr_a,  tbl[i].e_ovr);
            check($sformatf("tbl%0d_frame", i),   fer_a,  tbl[i].e_fer);
            check($sformatf("tbl%0d_parity", i),  per_a,  0);
        end
        check("t2_no_tx_held", frames_a.size(), 0);
        @(negedge clk) en_a = 1;
        wait_frames(0, 4, 800);
        repeat (150) @(negedge clk);
        check("t2_frames", frames_a.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (frames_a.size() > 0) begin
                fr = frames_a.pop_front();
                check($sformatf("t2_echo%0d", k), fr, {2'b11, 8'(8'h11 * (k + 1)), 1'b0});
            end
        end
        check("t2_count_empty", cnt_a, 0);
        @(negedge clk) clr_a = 1;
        @(negedge clk) clr_a = 0;
        check("t2_overrun_clr", ovr_a, 0);

        // Reset in the middle of a transmitted data bit
        send(0, 8'hA5, 0, 0, 1);
        repeat (10) @(negedge clk);
        check("t6_busy_pre", busy_a, 1);
        @(negedge clk) rst = 1;
        @(negedge clk);
        check("t6_txd",   txd_a,  1);
        check("t6_count", cnt_a,  0);
        check("t6_busy",  busy_a, 0);
        rst = 0;
        repeat (20) @(negedge clk);
        check("t6_no_partial", frames_a.size(), 0);
        send(0, 8'h3C, 0, 0, 1);
        wait_frames(0, 1, 300);
        check("t6_frames", frames_a.size(), 1);
        if (frames_a.size() > 0) begin
            fr = frames_a.pop_front();
            check("t6_echo", fr, {2'b11, 8'h3C, 1'b0});
        end

        // Even parity instance
        s0 = strb_n_b;
        send(1, 8'h03, 1, 1, 1);
        check("t4_parity_err", per_b, 1);
        check("t4_bad_strobe", strb_n_b - s0, 0);
        check("t4_bad_count", cnt_b, 0);
        repeat (150) @(negedge clk);
        check("t4_no_echo", frames_b.size(), 0);
        send(1, 8'h03, 1, 0, 1);
        wait_frames(1, 1, 300);
        check("t4_frames", frames_b.size(), 1);
        check("t4_strobe", strb_n_b - s0, 1);
        check("t4_rxdata", last_b, 8'h03);
        if (frames_b.size() > 0) begin
            fr = frames_b.pop_front();
            check("t4_echo", fr, {1'b1, 1'b0, 8'h03, 1'b0});
        end
        check("t4_parity_sticky", per_b, 1);
        check("t4_frame_err", fer_b, 0);
        check("bit_width_a", wbad[0], 0);
        check("bit_width_b", wbad[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised successor to the simple UART echo-back. Receives serial frames on rxd, buffers accepted bytes in a FIFO and retransmits them on txd in order. Configurable frame format, FIFO depth, TX flow control and sticky error reporting. Sits between the board UART pins and the top-level LED/status logic.

Parameters:
CLOCK_FREQUENCY, 100_000_000, clk frequency in Hz
BAUD_RATE, 115200, line rate; CPB = CLOCK_FREQUENCY/BAUD_RATE (integer division, must be >= 4)
DATA_BITS, 8, data bits per frame, 5..8, LSB first
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits generated by TX (1 or 2); RX checks the first only
FIFO_DEPTH, 16, entries, power of two >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
rxd  input  1  asynchronous serial input, idle high
txd  output  1  serial output, idle high
tx_enable  input  1  1: TX may pop FIFO; 0: hold bytes (current frame completes)
clr_err  input  1  one-cycle pulse clears all sticky error flags
rx_strobe  output  1  one-cycle pulse when a byte is accepted into the FIFO
rx_data  output  DATA_BITS  last accepted byte, valid with rx_strobe
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
fifo_full  output  1  fifo_count == FIFO_DEPTH
tx_busy  output  1  TX FSM not in IDLE
overrun_err  output  1  sticky: byte dropped because FIFO full
frame_err  output  1  sticky: first stop bit sampled 0
parity_err  output  1  sticky: parity mismatch

Behaviour:
- Reset values: txd=1, all other outputs 0, FIFO emptied, both FSMs IDLE, rxd synchroniser loaded with 1. Reset mid-frame aborts both frames; txd is 1 from the first post-reset edge.
- rxd passes a 2-FF synchroniser (2 cycles latency) before use.
- RX FSM: IDLE -> START on synchronised rxd==0. Sample at CPB/2. If still 0 -> DATA, else back to IDLE (glitch rejected). DATA: DATA_BITS samples spaced CPB, LSB first. -> PARITY (if PARITY!=0, one sample) -> STOP (one sample) -> IDLE.
- At the STOP sample cycle: stop==0 sets frame_err and discards the byte. Parity mismatch sets parity_err and discards the byte. Otherwise the byte is pushed and rx_strobe pulses, unless fifo_full (registered) is set; then the byte is dropped and overrun_err is set. A push is dropped when full even if a pop occurs in the same cycle.
- FIFO: simultaneous push and pop when not full and not empty leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - In IDLE with fifo_count!=0 and tx_enable=1: pop in cycle N; txd=0 from cycle N+1 for CPB cycles.
  - Then DATA_BITS data bits, optional parity bit (odd/even over the data bits), STOP_BITS stop bits, each CPB cycles.
  - Returns to IDLE after the final stop bit; the earliest next pop is the following cycle.
  - Deasserting tx_enable mid-frame does not truncate the frame.
- Error flags: clr_err clears all three. A set condition in the same cycle as clr_err wins (flag ends at 1).

Optional Feature:
UART_ECHO_CRLF_EN
- Defined: on accepting 0x0D (DATA_BITS==8 only), push 0x0D then 0x0A in consecutive cycles. This requires >= 2 free entries; otherwise both bytes are dropped and overrun_err is set. rx_strobe pulses once, with rx_data=0x0D.
- Undefined: 0x0D is treated as an ordinary byte.

Test Plan:
(All tests use CLOCK_FREQUENCY=1_000_000 and BAUD_RATE=100_000, giving CPB=10.)
1. 8N1: send 0x55 -> rx_strobe once with rx_data=0x55. txd falls 1 cycle after the pop and emits 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit 10 cycles. tx_busy then drops to 0.
2. FIFO_DEPTH=4, tx_enable=0: send 0x11,0x22,0x33,0x44,0x55 -> fifo_count=4, fifo_full=1, overrun_err=1. Raise tx_enable -> echoes 0x11..0x44 in order; 0x55 is never transmitted.
3. Send a frame with stop bit 0 -> frame_err=1, no rx_strobe, fifo_count stays 0. clr_err pulse -> frame_err=0.
4. PARITY=2: send 0x03 with parity bit 1 -> parity_err=1, no echo. Send 0x03 with parity bit 0 -> echoed with parity bit 0.
5. Drive rxd low for 3 cycles, then high -> RX returns to IDLE, no strobe, no error flags.
6. Assert rst during a TX data bit -> txd=1 on the next edge, fifo_count=0, tx_busy=0. A byte sent after reset echoes normally.
